tutor_counter_gen: RTL and testbench

Parametrised up/down counter with modulus, wrap/saturate mode, terminal-count flag, a clocked hold register and a tri-state output. It supersedes the fixed 4-bit tutorial counter/latch block. It sits between the board-level control inputs (CLR_N, CE, LOAD, DIR, SEL, LE, SNAP) and a shared output bus Q. Everything is synchronous to CLK except the asynchronous reset.

---
 rtl/tutor_counter_gen.sv | 100 ++++++++++
 tb/tb_tutor_counter_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tutor_counter_gen.sv
`default_nettype none
// ============================================================================
// Module      : tutor_counter_gen
// Description : Parametrised up/down modulus counter with wrap or saturate at
//               the range ends, a terminal-count flag for cascading, a
//               clocked hold register (load or snapshot) and a tri-state
//               output bus selecting counter or hold register.
// Revision    : 1.0 - initial release
// ============================================================================
module tutor_counter_gen #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             CE,
  input  logic             LOAD,
  input  logic             DIR,
  input  logic             SEL,
  input  logic             LE,
  input  logic             SNAP,
  input  logic [WIDTH-1:0] DATA,
  input  logic             OE,
  output logic [WIDTH-1:0] Q,
  output logic             TC
);

  // Refuse to elaborate with a modulus outside 2..2^WIDTH.
  generate
    if ((MODULUS < 2) || (longint'(MODULUS) > (longint'(1) << WIDTH))) begin : g_bad_modulus
      $error("tutor_counter_gen: MODULUS must lie in 2..2**WIDTH");
    end
  endgenerate

  // Highest counter value; MODULUS=2^WIDTH gives all-ones (natural roll-over).
  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_load_val;
  logic             w_at_max;
  logic             w_at_min;

  assign w_at_max   = (r_cnt == C_MAX);
  assign w_at_min   = (r_cnt == '0);
  // Out-of-range load data clamps to the top of the range.
  assign w_load_val = (DATA > C_MAX) ? C_MAX : DATA;

  // Next counter value: CE gates everything, then LOAD, then direction.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (CE) begin
      if (LOAD) begin
        w_cnt_nxt = w_load_val;
      end else if (DIR) begin
        if (w_at_max) begin
          w_cnt_nxt = (SATURATE != 0) ? C_MAX : '0;
        end else begin
          w_cnt_nxt = r_cnt + WIDTH'(1);
        end
      end else begin
        if (w_at_min) begin
          w_cnt_nxt = (SATURATE != 0) ? '0 : C_MAX;
        end else begin
          w_cnt_nxt = r_cnt - WIDTH'(1);
        end
      end
    end
  end

  // Counter register with asynchronous clear.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Hold register: LE captures DATA unclamped, else SNAP captures pre-edge count.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_hold <= '0;
    end else if (LE) begin
      r_hold <= DATA;
    end else if (SNAP) begin
      r_hold <= r_cnt;
    end
  end

  // Terminal count is forced low during reset and whenever a count will not occur.
  assign TC = CLR_N & CE & ~LOAD & (DIR ? w_at_max : w_at_min);

  // Shared bus driver; purely combinational from SEL/OE and the two registers.
  assign Q = OE ? (SEL ? r_hold : r_cnt) : {WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_tutor_counter_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_tutor_counter_gen
// Description : Scoreboard bench for tutor_counter_gen. Three instances share
//               stimulus: modulus 10 wrap, modulus 10 saturate, modulus 16
//               wrap. A released bus is pulled high, so Z reads as all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tutor_counter_gen;

  typedef struct packed {
    int unsigned step;
    logic [11:0] q;
    logic [2:0]  tc;
  } exp_t;

  logic       clk;
  logic       clr_n, ce, load, dir, le, snap, sel, oe;
  logic [3:0] data;

  tri1  [3:0] q0, q1, q2;
  wire        tc0, tc1, tc2;
  wire [11:0] q_all  = {q2, q1, q0};
  wire [2:0]  tc_all = {tc2, tc1, tc0};

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int unsigned step_no = 0;

  int mod_a [3] = '{10, 10, 16};
  int sat_a [3] = '{0, 1, 0};
  int m_cnt [3] = '{0, 0, 0};
  int m_hold[3] = '{0, 0, 0};

  tutor_counter_gen #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap10 (
    .CLK(clk), .CLR_N(clr_n), .CE(ce), .LOAD(load), .DIR(dir), .SEL(sel),
    .LE(le), .SNAP(snap), .DATA(data), .OE(oe), .Q(q0), .TC(tc0));

  tutor_counter_gen #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat10 (
    .CLK(clk), .CLR_N(clr_n), .CE(ce), .LOAD(load), .DIR(dir), .SEL(sel),
    .LE(le), .SNAP(snap), .DATA(data), .OE(oe), .Q(q1), .TC(tc1));

  tutor_counter_gen #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_wrap16 (
    .CLK(clk), .CLR_N(clr_n), .CE(ce), .LOAD(load), .DIR(dir), .SEL(sel),
    .LE(le), .SNAP(snap), .DATA(data), .OE(oe), .Q(q2), .TC(tc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: range arithmetic straight from the counting rules.
  function automatic void model_edge();
    for (int i = 0; i < 3; i++) begin
      int top = mod_a[i] - 1;
      int nc  = m_cnt[i];
      if (!clr_n) begin
        m_cnt[i]  = 0;
        m_hold[i] = 0;
      end else begin
        if (ce) begin
          if (load)
            nc = (int'(data) < top) ? int'(data) : top;
          else if (dir)
            nc = sat_a[i] != 0 ? ((m_cnt[i] + 1 > top) ? top : m_cnt[i] + 1)
                               : (m_cnt[i] + 1) % mod_a[i];
          else
            nc = sat_a[i] != 0 ? ((m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1)
                               : (m_cnt[i] + mod_a[i] - 1) % mod_a[i];
        end
        if (le)        m_hold[i] = int'(data);
        else if (snap) m_hold[i] = m_cnt[i];
        m_cnt[i] = nc;
      end
    end
  endfunction

  function automatic logic [3:0] exp_q(int i);
    if (!oe) return 4'hF;
    return sel ? 4'(m_hold[i]) : 4'(m_cnt[i]);
  endfunction

  function automatic logic exp_tc(int i);
    logic at_end;
    at_end = dir ? (m_cnt[i] == mod_a[i] - 1) : (m_cnt[i] == 0);
    return clr_n & ce & ~load & at_end;
  endfunction

  // One cycle: model takes the edge, new inputs go on, expectation is queued.
  task automatic cyc(input logic i_clr, input logic i_ce, input logic i_ld,
                     input logic i_dir, input logic i_le, input logic i_snap,
                     input logic i_sel, input logic i_oe, input logic [3:0] i_data);
    exp_t e;
    @(posedge clk);
    model_edge();
    #2;
    clr_n = i_clr; ce = i_ce; load = i_ld; dir = i_dir;
    le = i_le; snap = i_snap; sel = i_sel; oe = i_oe; data = i_data;
    if (!clr_n) begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[i]  = 0;
        m_hold[i] = 0;
      end
    end
    step_no++;
    e.step = step_no;
    e.q    = '0;
    e.tc   = '0;
    for (int i = 0; i < 3; i++) begin
      e.q[i*4 +: 4] = exp_q(i);
      e.tc[i]       = exp_tc(i);
    end
    sb.push_back(e);
  endtask

  // Monitor: outputs are settled mid-cycle; pop and compare each instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
          checks++;
          if (q_all[i*4 +: 4] !== e.q[i*4 +: 4]) begin
            errors++;
            $display("FAIL q dut%0d step%0d got=%h exp=%h", i, e.step,
                     q_all[i*4 +: 4], e.q[i*4 +: 4]);
          end
          checks++;
          if (tc_all[i] !== e.tc[i]) begin
            errors++;
            $display("FAIL tc dut%0d step%0d got=%b exp=%b", i, e.step,
                     tc_all[i], e.tc[i]);
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios first, then random traffic.
  initial begin
    clr_n = 1'b1; ce = 1'b0; load = 1'b0; dir = 1'b0; le = 1'b0;
    snap = 1'b0; sel = 1'b0; oe = 1'b1; data = 4'd0;
    #1 clr_n = 1'b0;

    // args: clr ce ld dir le snap sel oe data
    cyc(0,0,0,0,0,0,0,1,4'd0);
    cyc(0,1,0,1,0,0,1,1,4'd0);
    cyc(1,1,1,1,0,0,0,1,4'd6);
    cyc(1,1,1,1,0,0,0,1,4'd13);
    cyc(1,1,1,1,0,0,0,1,4'd6);
    repeat (6) cyc(1,1,0,1,0,0,0,1,4'd0);
    repeat (3) cyc(1,1,0,0,0,0,0,1,4'd0);
    repeat (3) cyc(1,0,0,0,0,0,0,1,4'd0);
    cyc(1,0,1,0,0,0,0,1,4'd3);
    cyc(1,1,1,1,0,0,0,1,4'd8);
    repeat (4) cyc(1,1,0,1,0,0,0,1,4'd0);
    cyc(1,1,1,0,0,0,0,1,4'd1);
    repeat (3) cyc(1,1,0,0,0,0,0,1,4'd0);
    cyc(1,1,0,1,1,0,1,1,4'd1);
    cyc(1,1,0,1,1,0,1,1,4'd5);
    cyc(1,1,0,1,0,0,1,1,4'd2);
    cyc(1,1,1,1,0,0,1,1,4'd4);
    cyc(1,1,0,1,0,1,1,1,4'd0);
    cyc(1,1,0,1,1,1,1,1,4'd7);
    cyc(1,1,0,1,0,0,1,1,4'd15);
    cyc(1,0,0,1,0,0,0,0,4'd0);
    cyc(1,0,0,1,0,0,1,0,4'd0);
    cyc(1,0,0,1,0,0,1,1,4'd0);
    cyc(1,0,0,1,0,0,0,1,4'd0);
    cyc(1,1,1,1,0,0,0,1,4'd7);
    cyc(1,0,0,1,1,0,0,1,4'd5);
    cyc(1,0,0,1,0,0,1,1,4'd0);
    cyc(0,1,0,1,0,0,0,1,4'd0);
    cyc(0,1,0,1,0,0,1,1,4'd0);
    cyc(1,1,0,1,0,0,0,1,4'd0);
    repeat (2) cyc(1,1,0,1,0,0,0,1,4'd0);

    for (int n = 0; n < 300; n++) begin
      cyc($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 5) == 0, 1'($urandom), $urandom_range(0, 5) == 0,
          $urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 7) != 0,
          4'($urandom));
    end

    cyc(1,1,0,1,0,0,0,1,4'd0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog timeout reached=1 exp=0");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
